// File: rtl/jtframe_credits_pkg.sv
// jtframe_credits_pkg: control codes, geometry and state encoding for the credits writer
package jtframe_credits_pkg;
    localparam logic [7:0] CC_ATTR = 8'h01;
    localparam logic [7:0] CC_GOTO = 8'h02;
    localparam logic [7:0] CC_LF   = 8'h0A;
    localparam logic [7:0] CC_FF   = 8'h0C;
    localparam logic [7:0] CC_CR   = 8'h0D;
    localparam int COLS    = 32;
    localparam int ROWS    = 32;
    localparam int VRAM_AW = 10;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG_ATTR,
        ST_ARG_COL,
        ST_ARG_ROW,
        ST_CLEAR
    } state_t;
    function automatic logic is_print(input logic [7:0] b);
        return b >= 8'h20 && b <= 8'h7E;
    endfunction
endpackage

// File: rtl/jtframe_credits_writer.sv
// jtframe_credits_writer: byte-stream to 32x32 credits VRAM writer with cursor, attribute and clear
module jtframe_credits_writer
    import jtframe_credits_pkg::*;
#(
    parameter logic [7:0] CLR_CHAR   = 8'h20,
    parameter bit         CLR_ON_RST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_din,
    output logic               vram_we,
    output logic               busy,
    output logic [4:0]         cur_col,
    output logic [4:0]         cur_row
);
    state_t               state_q, state_d;
    logic [10:0]          clr_q, clr_d, clr_inc;
    logic [4:0]           col_q, col_d, row_q, row_d;
    logic                 attr_q, attr_d;
    logic                 we_q, we_d;
    logic [VRAM_AW-1:0]   addr_q, addr_d;
    logic [7:0]           din_q, din_d;
    logic                 accept;

    assign accept  = in_valid && in_ready;
    // the clear ends once the counter would carry into bit 10, i.e. after address 1023
    assign clr_inc = clr_q + 11'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR_ON_RST ? ST_CLEAR : ST_IDLE;
            clr_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            attr_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            attr_q  <= attr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept)
                    state_d = in_data == CC_ATTR ? ST_ARG_ATTR :
                              in_data == CC_GOTO ? ST_ARG_COL  :
                              in_data == CC_FF   ? ST_CLEAR    : ST_IDLE;
            end
            ST_ARG_ATTR: state_d = accept ? ST_IDLE : ST_ARG_ATTR;
            ST_ARG_COL:  state_d = accept ? ST_ARG_ROW : ST_ARG_COL;
            ST_ARG_ROW:  state_d = accept ? ST_IDLE : ST_ARG_ROW;
            ST_CLEAR:    state_d = clr_inc[10] ? ST_IDLE : ST_CLEAR;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        clr_d  = state_q == ST_CLEAR ? clr_inc : 11'd0;
        col_d  = col_q;
        row_d  = row_q;
        attr_d = attr_q;
        we_d   = 1'b0;
        addr_d = addr_q;
        din_d  = din_q;
        if (state_q == ST_CLEAR) begin
            we_d   = 1'b1;
            addr_d = clr_q[VRAM_AW-1:0];
            din_d  = {1'b0, CLR_CHAR[6:0]};
            col_d  = clr_inc[10] ? 5'd0 : col_q;
            row_d  = clr_inc[10] ? 5'd0 : row_q;
        end else if (accept) begin
            if (state_q == ST_IDLE && is_print(in_data)) begin
                we_d   = 1'b1;
                addr_d = {row_q, col_q};
                din_d  = {attr_q, in_data[6:0]};
                col_d  = col_q + 5'd1;
                row_d  = col_q == 5'd31 ? row_q + 5'd1 : row_q;
            end else if (state_q == ST_IDLE && in_data == CC_LF) begin
                col_d = 5'd0;
                row_d = row_q + 5'd1;
            end else if (state_q == ST_IDLE && in_data == CC_CR) begin
                col_d = 5'd0;
            end
            attr_d = state_q == ST_ARG_ATTR ? in_data[0]   : attr_q;
            col_d  = state_q == ST_ARG_COL  ? in_data[4:0] : col_d;
            row_d  = state_q == ST_ARG_ROW  ? in_data[4:0] : row_d;
        end
    end

    always_comb begin
        in_ready  = state_q != ST_CLEAR;
        busy      = state_q == ST_CLEAR;
        vram_we   = we_q;
        vram_addr = addr_q;
        vram_din  = din_q;
        cur_col   = col_q;
        cur_row   = row_q;
    end
endmodule

// File: tb/tb_jtframe_credits_writer.sv
// tb_jtframe_credits_writer: randomized and directed checks against a cell-position reference model
module tb_jtframe_credits_writer;
    logic       clk, rst, in_valid, in_ready, vram_we, busy;
    logic [7:0] in_data, vram_din;
    logic [9:0] vram_addr;
    logic [4:0] cur_col, cur_row;
    logic       rst0, in_valid0, in_ready0, vram_we0, busy0;
    logic [7:0] in_data0, vram_din0;
    logic [9:0] vram_addr0;
    logic [4:0] cur_col0, cur_row0;

    int checks = 0, errors = 0;
    // reference model: cursor as a linear cell index, clear as a countdown
    int m_pos, m_attr, m_arg, m_left, m_caddr;
    int e_we, e_addr, e_din;
    int wcnt, last_addr, last_din, w0cnt, last0;

    jtframe_credits_writer #(.CLR_CHAR(8'h20), .CLR_ON_RST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .vram_addr(vram_addr), .vram_din(vram_din), .vram_we(vram_we), .busy(busy),
        .cur_col(cur_col), .cur_row(cur_row));

    jtframe_credits_writer #(.CLR_CHAR(8'h20), .CLR_ON_RST(1'b0)) u_dut0 (
        .clk(clk), .rst(rst0), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .vram_addr(vram_addr0), .vram_din(vram_din0), .vram_we(vram_we0), .busy(busy0),
        .cur_col(cur_col0), .cur_row(cur_row0));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic m_step();
        int b;
        e_we = 0;
        b = int'(in_data);
        if (rst) begin
            m_pos = 0; m_attr = 0; m_arg = 0; m_left = 1024; m_caddr = 0;
            return;
        end
        if (m_left > 0) begin
            e_we = 1; e_addr = m_caddr; e_din = 8'h20;
            m_caddr++; m_left--;
            if (m_left == 0) m_pos = 0;
            return;
        end
        if (!in_valid) return;
        if (m_arg == 1) begin
            m_attr = b % 2; m_arg = 0;
        end else if (m_arg == 2) begin
            m_pos = m_pos - m_pos % 32 + b % 32; m_arg = 3;
        end else if (m_arg == 3) begin
            m_pos = (b % 32) * 32 + m_pos % 32; m_arg = 0;
        end else if (b >= 32 && b <= 126) begin
            e_we = 1; e_addr = m_pos; e_din = m_attr * 128 + b % 128;
            m_pos = (m_pos + 1) % 1024;
        end else if (b == 8'h0A) m_pos = ((m_pos / 32 + 1) % 32) * 32;
        else if (b == 8'h0D) m_pos = m_pos - m_pos % 32;
        else if (b == 8'h01) m_arg = 1;
        else if (b == 8'h02) m_arg = 2;
        else if (b == 8'h0C) begin
            m_left = 1024; m_caddr = 0;
        end
    endtask

    task automatic cycle();
        m_step();
        @(posedge clk);
        #1;
        chk("we", vram_we, e_we);
        if (e_we != 0) begin
            chk("addr", vram_addr, e_addr);
            chk("din", vram_din, e_din);
        end
        chk("busy", busy, m_left > 0);
        chk("in_ready", in_ready, m_left == 0);
        chk("cur_col", cur_col, m_pos % 32);
        chk("cur_row", cur_row, m_pos / 32);
        if (vram_we) begin
            wcnt++; last_addr = vram_addr; last_din = vram_din;
        end
        if (vram_we0) begin
            w0cnt++; last0 = vram_addr0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit acc;
        in_valid = 1; in_data = b;
        for (int n = 0; n < 1100; n++) begin
            acc = m_left == 0;
            cycle();
            if (acc) begin
                in_valid = 0;
                return;
            end
        end
        in_valid = 0;
        chk("send_timeout", 1, 0);
    endtask

    initial begin
        int n, low;
        int r;
        rst = 1; in_valid = 0; in_data = 0;
        rst0 = 1; in_valid0 = 0; in_data0 = 0;
        wcnt = 0; w0cnt = 0; last_addr = 0; last_din = 0; last0 = 0;
        repeat (3) cycle();
        chk("rst_busy", busy, 1);
        chk("rst_ready", in_ready, 0);
        chk("rst_we", vram_we, 0);
        rst = 0;
        wcnt = 0; n = 0;
        while (busy && n < 1100) begin
            cycle(); n++;
        end
        chk("init_busy_cycles", n, 1024);
        chk("init_writes", wcnt, 1024);
        chk("init_last_addr", last_addr, 1023);
        chk("init_last_din", last_din, 8'h20);
        chk("init_ready", in_ready, 1);

        send(8'h41);
        send(8'h42);
        chk("ab_addr", last_addr, 1);
        chk("ab_din", last_din, 8'h42);
        chk("ab_col", cur_col, 2);

        send(8'h01); send(8'h01); send(8'h02); send(8'h1F); send(8'h1F);
        wcnt = 0;
        send(8'h5A);
        chk("z_writes", wcnt, 1);
        chk("z_addr", last_addr, 10'h3FF);
        chk("z_din", last_din, 8'hDA);
        chk("z_col", cur_col, 0);
        chk("z_row", cur_row, 0);
        send(8'h01); send(8'h00);

        send(8'h02); send(8'h05); send(8'h03);
        wcnt = 0;
        send(8'h0A);
        chk("lf_col", cur_col, 0);
        chk("lf_row", cur_row, 4);
        send(8'h0D);
        chk("cr_col", cur_col, 0);
        chk("cr_row", cur_row, 4);
        send(8'h02); send(8'hE7); send(8'h04);
        chk("goto_col", cur_col, 7);
        send(8'h0D);
        chk("cr7_col", cur_col, 0);
        chk("cr7_row", cur_row, 4);
        chk("ctrl_nowrite", wcnt, 0);

        in_valid = 1; in_data = 8'h0C;
        cycle();
        in_data = 8'h41;
        low = in_ready ? 0 : 1;
        n = 0;
        while (n < 1100) begin
            r = m_left == 0;
            cycle(); n++;
            if (r != 0) break;
            if (!in_ready) low++;
        end
        in_valid = 0;
        chk("ff_ready_low", low, 1024);
        chk("ff_q_addr", last_addr, 0);
        chk("ff_q_din", last_din, 8'h41);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            in_valid = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 999) == 0;
            in_data = r < 70 ? 8'($urandom_range(32, 126)) : r < 78 ? 8'h01 : r < 86 ? 8'h02 :
                      r < 90 ? 8'h0A : r < 94 ? 8'h0D : r < 95 ? 8'h0C : 8'($urandom);
            cycle();
        end
        rst = 0; in_valid = 0;
        n = 0;
        while (busy && n < 1100) begin
            cycle(); n++;
        end

        rst0 = 0;
        cycle();
        chk("d0_busy", busy0, 0);
        chk("d0_ready", in_ready0, 1);
        in_valid0 = 1; in_data0 = 8'h0C;
        cycle();
        in_valid0 = 0;
        w0cnt = 0; n = 0;
        while (!(vram_we0 && vram_addr0 == 10'd500) && n < 1100) begin
            cycle(); n++;
        end
        chk("d0_writes_at_500", w0cnt, 501);
        chk("d0_busy_mid", busy0, 1);
        rst0 = 1;
        cycle();
        chk("d0_rst_we", vram_we0, 0);
        chk("d0_rst_busy", busy0, 0);
        chk("d0_rst_ready", in_ready0, 1);
        chk("d0_rst_col", cur_col0, 0);
        chk("d0_rst_row", cur_row0, 0);
        rst0 = 0;
        n = w0cnt;
        repeat (50) cycle();
        chk("d0_no_more_writes", w0cnt, n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtframe_credits_writer.md
Name: jtframe_credits_writer

Overview:
Character-stream writer for the 32x32 credits/message VRAM. It accepts a byte stream over a valid/ready handshake, interprets printable ASCII and a small set of control codes, and drives the VRAM write port of the credits overlay: vram_addr, vram_din and vram_we. The stream source can be a debug CPU, the OSD firmware or a ROM-driven message player, so messages are composed at run time instead of coming from a static msg.bin.

Parameters:
CLR_CHAR, 8'h20, character code written to every cell during a clear (attribute bit forced to 0)
CLR_ON_RST, 1, 1 = run a full-screen clear immediately after reset; 0 = start in IDLE

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
in_data  in  8  stream byte
in_valid  in  1  in_data is valid
in_ready  out  1  block can accept a byte this cycle
vram_addr  out  10  cell address {row[4:0], col[4:0]}
vram_din  out  8  cell data {attr, char[6:0]}
vram_we  out  1  one-cycle write strobe
busy  out  1  high while a clear is in progress
cur_col  out  5  cursor column
cur_row  out  5  cursor row

Behaviour:
- Clocking: single clock clk; synchronous active-high reset rst. All outputs are registered.
- Reset values: vram_we=0, vram_addr=0, vram_din=0, cursor (0,0), attr=0. If CLR_ON_RST=1: busy=1, in_ready=0, state CLEAR with clear counter 0. Otherwise: busy=0, in_ready=1, state IDLE.
- Handshake: a byte is accepted on a rising edge with in_valid && in_ready. in_ready is combinational from state: high in IDLE, ARG_ATTR, ARG_COL and ARG_ROW; low in CLEAR. in_valid may drop at any time without a protocol error.
- States: IDLE, ARG_ATTR, ARG_COL, ARG_ROW, CLEAR.
- IDLE, byte accepted:
  - 8'h20..8'h7E (printable): next cycle vram_we=1, vram_addr={row,col}, vram_din={attr,byte[6:0]}. Then col+1. When col wraps 31->0, row+1; row 31 wraps to 0. There is no scrolling.
  - 8'h0A (LF): col=0, row+1 (wrapping). No write.
  - 8'h0D (CR): col=0. No write.
  - 8'h01: go to ARG_ATTR; next accepted byte sets attr=byte[0], return to IDLE.
  - 8'h02: go to ARG_COL; next byte sets col=byte[4:0]; go to ARG_ROW; next byte sets row=byte[4:0]; return to IDLE. Upper bits are ignored.
  - 8'h0C (FF): go to CLEAR.
  - Any other byte: consumed, no effect.
- vram_we is a single-cycle pulse. Back-to-back printables give one write per cycle, with latency 1 cycle from acceptance to the strobe.
- CLEAR:
  - Entry: busy=1 on the cycle after FF is accepted, or out of reset.
  - Writes: one write per cycle, addr 0..1023 in order, din={1'b0, CLR_CHAR[6:0]}.
  - Exit: after the write to addr 1023, cursor=(0,0), attr unchanged, busy=0 and state IDLE on the following cycle.
  - Total: exactly 1024 vram_we pulses per clear.
  - An FF received in any ARG_* state is taken as an argument, not a clear.
- Reset mid-operation (mid-clear or mid-argument): aborts immediately and reloads the reset values. A pending ARG sequence is discarded. The clear counter restarts from 0 when CLR_ON_RST=1.
- Widths: cursor counters are 5 bits each and wrap naturally. The clear counter is 11 bits; termination is detected on bit 10.

Decomposition:
- Shared package jtframe_credits_pkg:
  - Control code constants: CC_ATTR=8'h01, CC_GOTO=8'h02, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D.
  - Geometry constants: COLS=32, ROWS=32, VRAM_AW=10.
  - State encoding.
- No sub-module; the block is a single FSM plus the cursor and clear counters (about 150-200 RTL lines).

Test Plan:
- CLR_ON_RST=1, release rst -> busy high for 1024 cycles, 1024 writes addr 0..1023, din=8'h20 each, then in_ready=1 and cursor (0,0).
- Send "AB" from (0,0) with attr 0 -> writes (addr 0, 8'h41) then (addr 1, 8'h42) on consecutive cycles; cur_col=2.
- Send 01 01, 02 1F 1F, "Z" -> single write addr 10'h3FF, din 8'hDA; cursor wraps to (0,0).
- Cursor at (5,3); send 0A then 0D -> no writes; cursor (0,4), then (0,4) again. Send 0D with col=7 -> col 0, row unchanged.
- Send 0C with in_valid held high and bytes queued -> in_ready low during the 1024-cycle clear, queued byte 8'h41 accepted afterwards and written to addr 0.
- Assert rst at clear write 500 with CLR_ON_RST=0 -> next cycle vram_we=0, busy=0, in_ready=1, cursor (0,0), no further writes.
